// File: rtl/pulse_pkg.sv
// pulse_pkg: frame layout, parameter reset defaults and FSM state shared by the loader and sequencer.
package pulse_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam int PAYLOAD_LEN = 18;
  localparam int SHADOW_MSB = PAYLOAD_LEN * 8 - 1;
  localparam int OFF_PER = 0;
  localparam int OFF_P1WID = 4;
  localparam int OFF_DEL = 6;
  localparam int OFF_P2WID = 8;
  localparam int OFF_NUT_W = 10;
  localparam int OFF_NUT_D = 11;
  localparam int OFF_CP = 13;
  localparam int OFF_P_BL = 14;
  localparam int OFF_P_BL_OFF = 15;
  localparam int OFF_BL = 17;
  localparam logic [31:0] DEF_PER = 32'h0001_0000;
  localparam logic [15:0] DEF_P1WID = 16'd30;
  localparam logic [15:0] DEF_DEL = 16'd200;
  localparam logic [15:0] DEF_P2WID = 16'd30;
  localparam logic [7:0] DEF_NUT_W = 8'd50;
  localparam logic [15:0] DEF_NUT_D = 16'd300;
  localparam logic [7:0] DEF_CP = 8'd3;
  localparam logic [7:0] DEF_P_BL = 8'd50;
  localparam logic [15:0] DEF_P_BL_OFF = 16'd100;
  localparam logic DEF_BL = 1'b1;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
endpackage

// File: rtl/pulse_param_loader_if.sv
// pulse_param_loader_if: received-byte stream from the UART into the parameter loader.
interface pulse_param_loader_if;
  logic [7:0] rx_data;
  logic rx_valid;
  modport master(output rx_data, rx_valid);
  modport slave(input rx_data, rx_valid);
endinterface

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte watchdog; a byte on the expiry cycle suppresses expiry.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYC);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (reset || clr || !en || expire) ? '0 : r_cnt + 1'b1;
  assign expire = en && !clr && r_cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/pulse_param_loader.sv
// pulse_param_loader: parses sync/payload/checksum frames and atomically commits sequencer parameters.
module pulse_param_loader #(
  parameter logic [7:0] SYNC_BYTE = pulse_pkg::SYNC_BYTE,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  pulse_param_loader_if.slave  rx,
  output logic [31:0]          per,
  output logic [15:0]          p1wid,
  output logic [15:0]          del,
  output logic [15:0]          p2wid,
  output logic [7:0]           nut_w,
  output logic [15:0]          nut_d,
  output logic [7:0]           cp,
  output logic [7:0]           p_bl,
  output logic [15:0]          p_bl_off,
  output logic                 bl,
  output logic                 rx_done,
  output logic                 busy,
  output logic [7:0]           err_count
);
  import pulse_pkg::*;
  localparam int M = SHADOW_MSB;
  state_t r_state, w_next;
  logic [M:0] r_shadow;
  logic [4:0] r_idx;
  logic [7:0] r_sum;
  logic w_byte, w_last, w_expire, w_commit, w_drop;
  assign w_byte = rx.rx_valid;
  assign w_last = r_idx == 5'(PAYLOAD_LEN - 1);
  loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk), .reset(reset), .en(busy), .clr(w_byte), .expire(w_expire)
  );
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = w_expire ? IDLE :
             !w_byte ? r_state :
             r_state == IDLE ? (rx.rx_data == SYNC_BYTE ? PAYLOAD : IDLE) :
             r_state == PAYLOAD ? (w_last ? CHECK : PAYLOAD) : IDLE;
  end
  always_comb begin
    busy = r_state != IDLE;
    w_commit = r_state == CHECK && w_byte && rx.rx_data == r_sum;
    w_drop = w_expire || (r_state == CHECK && w_byte && rx.rx_data != r_sum);
  end
  // every frame shifts all 18 bytes through, so the shadow never needs clearing between frames
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_idx <= '0;
      r_sum <= '0;
    end else if (w_byte && r_state == IDLE) begin
      r_idx <= '0;
      r_sum <= '0;
    end else if (w_byte && r_state == PAYLOAD) begin
      r_shadow <= {r_shadow[M-8:0], rx.rx_data};
      r_sum <= r_sum + rx.rx_data;
      r_idx <= r_idx + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      per <= DEF_PER;
      p1wid <= DEF_P1WID;
      del <= DEF_DEL;
      p2wid <= DEF_P2WID;
      nut_w <= DEF_NUT_W;
      nut_d <= DEF_NUT_D;
      cp <= DEF_CP;
      p_bl <= DEF_P_BL;
      p_bl_off <= DEF_P_BL_OFF;
      bl <= DEF_BL;
      rx_done <= 1'b0;
      err_count <= '0;
    end else begin
      rx_done <= w_commit;
      if (w_commit) begin
        per <= r_shadow[M-8*OFF_PER -: 32];
        p1wid <= r_shadow[M-8*OFF_P1WID -: 16];
        del <= r_shadow[M-8*OFF_DEL -: 16];
        p2wid <= r_shadow[M-8*OFF_P2WID -: 16];
        nut_w <= r_shadow[M-8*OFF_NUT_W -: 8];
        nut_d <= r_shadow[M-8*OFF_NUT_D -: 16];
        cp <= r_shadow[M-8*OFF_CP -: 8];
        p_bl <= r_shadow[M-8*OFF_P_BL -: 8];
        p_bl_off <= r_shadow[M-8*OFF_P_BL_OFF -: 16];
        bl <= r_shadow[M-8*OFF_BL-7];
      end
      if (w_drop && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pulse_param_loader.sv
// tb_pulse_param_loader: random frames scored against a frame-level model; monitor checks commits and live outputs.
module tb_pulse_param_loader;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
  logic [7:0] nut_w, cp, p_bl, err_count;
  logic bl, rx_done, busy;
  always #5 clk = ~clk;
  pulse_param_loader_if rx();
  pulse_param_loader #(.SYNC_BYTE(8'hAA), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl),
    .p_bl_off(p_bl_off), .bl(bl), .rx_done(rx_done), .busy(busy), .err_count(err_count)
  );
  typedef struct {
    logic [31:0] per;
    logic [15:0] p1wid, del, p2wid;
    logic [7:0] nut_w;
    logic [15:0] nut_d;
    logic [7:0] cp, p_bl;
    logic [15:0] p_bl_off;
    logic bl;
    logic [7:0] err;
  } exp_t;
  typedef logic [7:0] frame_t [18];
  exp_t exp_q[$];
  exp_t live;
  int exp_err;
  int checks = 0;
  int errors = 0;
  logic prev_done = 1'b0;
  frame_t f1 = '{8'h00, 8'h00, 8'hC3, 8'h50, 8'h00, 8'h28, 8'h01, 8'h2C, 8'h00,
                 8'h50, 8'h00, 8'h00, 8'h00, 8'h01, 8'h32, 8'h00, 8'h64, 8'h01};
  function automatic exp_t defaults();
    return '{32'h0001_0000, 16'd30, 16'd200, 16'd30, 8'd50, 16'd300, 8'd3, 8'd50, 16'd100, 1'b1, 8'd0};
  endfunction
  function automatic exp_t model(input frame_t p, input int err);
    exp_t e;
    e.per = {p[0], p[1], p[2], p[3]};
    e.p1wid = {p[4], p[5]};
    e.del = {p[6], p[7]};
    e.p2wid = {p[8], p[9]};
    e.nut_w = p[10];
    e.nut_d = {p[11], p[12]};
    e.cp = p[13];
    e.p_bl = p[14];
    e.p_bl_off = {p[15], p[16]};
    e.bl = p[17][0];
    e.err = 8'(err);
    return e;
  endfunction
  function automatic logic [159:0] pack(input exp_t e);
    return {7'd0, e.per, e.p1wid, e.del, e.p2wid, e.nut_w, e.nut_d, e.cp, e.p_bl, e.p_bl_off, e.bl};
  endfunction
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, expv);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rx_done got 1 want 0");
        end else begin
          live = exp_q.pop_front();
          chk("commit_err_count", 160'(err_count), 160'(live.err));
        end
        chk("rx_done_one_cycle", 160'(rx_done && prev_done), 160'(0));
      end
      prev_done = rx_done;
      chk("live_params", {7'd0, per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl}, pack(live));
    end else prev_done = 1'b0;
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx.rx_data = b;
    rx.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx.rx_valid = 1'b0;
  endtask
  function automatic int gap(input int mode);
    return mode == 0 ? 0 : mode == 1 ? TO - 1 :
           ($urandom_range(0, 3) == 0 ? TO - 1 : int'($urandom_range(0, 3)));
  endfunction
  task automatic send_frame(input frame_t p, input bit good, input int mode);
    logic [7:0] s;
    s = 8'd0;
    foreach (p[i]) s = s + p[i];
    send_byte(8'hAA);
    for (int i = 0; i < 18; i++) begin
      idle(gap(mode));
      send_byte(p[i]);
    end
    idle(gap(mode));
    if (good) exp_q.push_back(model(p, exp_err));
    send_byte(good ? s : s + 8'd1);
    if (!good) exp_err = exp_err < 255 ? exp_err + 1 : 255;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    rx.rx_valid = 1'b0;
    idle(2);
    exp_q.delete();
    live = defaults();
    exp_err = 0;
    reset = 1'b0;
  endtask
  function automatic frame_t rand_frame();
    frame_t p;
    foreach (p[i]) p[i] = 8'($urandom);
    return p;
  endfunction
  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    frame_t fa, fb;
    rx.rx_valid = 1'b0;
    rx.rx_data = 8'h00;
    reset = 1'b1;
    live = defaults();
    exp_err = 0;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("reset_per", 160'(per), 160'(32'h10000));
    chk("reset_cp", 160'(cp), 160'(3));
    chk("reset_bl", 160'(bl), 160'(1));
    chk("reset_busy", 160'(busy), 160'(0));
    chk("reset_rx_done", 160'(rx_done), 160'(0));
    chk("reset_err", 160'(err_count), 160'(0));
    send_frame(f1, 1'b1, 0);
    chk("t1_rx_done", 160'(rx_done), 160'(1));
    chk("t1_per", 160'(per), 160'(50000));
    chk("t1_p1wid", 160'(p1wid), 160'(40));
    chk("t1_del", 160'(del), 160'(300));
    chk("t1_p2wid", 160'(p2wid), 160'(80));
    chk("t1_cp", 160'(cp), 160'(1));
    chk("t1_p_bl_off", 160'(p_bl_off), 160'(100));
    idle(1);
    chk("t1_rx_done_drop", 160'(rx_done), 160'(0));
    send_frame(f1, 1'b0, 0);
    idle(1);
    chk("t2_err", 160'(err_count), 160'(1));
    chk("t2_busy", 160'(busy), 160'(0));
    send_byte(8'hAA);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    idle(TO - 1);
    chk("t3_busy_before_expiry", 160'(busy), 160'(1));
    idle(1);
    chk("t3_busy_after_expiry", 160'(busy), 160'(0));
    exp_err = exp_err + 1;
    chk("t3_err", 160'(err_count), 160'(exp_err));
    send_frame(rand_frame(), 1'b1, 0);
    send_frame(rand_frame(), 1'b1, 1);
    send_byte(8'h13);
    send_byte(8'h55);
    send_byte(8'h00);
    send_frame(rand_frame(), 1'b1, 2);
    fa = rand_frame();
    fb = rand_frame();
    send_frame(fa, 1'b1, 0);
    send_frame(fb, 1'b1, 0);
    idle(1);
    chk("t5_second_frame", {7'd0, per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl}, pack(model(fb, 0)));
    for (int n = 0; n < 30; n++) begin
      send_frame(rand_frame(), 1'($urandom_range(0, 3) != 0), 2);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);
    chk("random_err", 160'(err_count), 160'(exp_err));
    send_byte(8'hAA);
    for (int i = 0; i < 7; i++) send_byte(f1[i]);
    do_reset();
    for (int i = 7; i < 18; i++) send_byte(f1[i]);
    send_byte(8'h50);
    idle(3);
    chk("t6_per", 160'(per), 160'(32'h10000));
    chk("t6_cp", 160'(cp), 160'(3));
    chk("t6_err", 160'(err_count), 160'(0));
    chk("t6_busy", 160'(busy), 160'(0));
    for (int n = 0; n < 260; n++) send_frame(rand_frame(), 1'b0, 0);
    idle(1);
    chk("sat_err", 160'(err_count), 160'(255));
    send_frame(rand_frame(), 1'b1, 0);
    idle(5);
    chk("pending_commits", 160'(exp_q.size()), 160'(0));
    chk("final_err", 160'(err_count), 160'(exp_err));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
